// File: rtl/switch_priority_debouncer.sv
// -----------------------------------------------------------------------------
// switch_priority_debouncer
//   Synchronises and debounces a bank of N asynchronous slide switches, then
//   encodes the accepted vector into a 1-based digit code for the Sudoku
//   value-entry path.
//
// Parameters
//   N               number of switches; bit i encodes to value i+1
//   W               code width, 2**W must exceed N
//   DEBOUNCE_CYCLES consecutive stable cycles before a new vector is accepted
//   STRICT          0 = highest set bit wins, 1 = exactly one bit or code 0
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      synchronous active-high reset
//   switch_i   raw asynchronous switch levels
//   code_o     encoded digit, 0 = none/invalid
//   valid_o    high whenever code_o != 0
//   multi_o    more than one bit of the accepted vector is set
//   changed_o  one-cycle pulse coincident with a new code_o value
// -----------------------------------------------------------------------------
module switch_priority_debouncer #(
   parameter int unsigned N               = 9,
   parameter int unsigned W               = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned STRICT          = 0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] switch_i,
   output logic [W-1:0] code_o,
   output logic         valid_o,
   output logic         multi_o,
   output logic         changed_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned PW = $clog2(N + 1);

   // Elaboration-time parameter sanity
   if ((2 ** W) <= N) begin : g_bad_width
      $fatal(1, "switch_priority_debouncer: 2**W must exceed N");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $fatal(1, "switch_priority_debouncer: DEBOUNCE_CYCLES must be >= 1");
   end

   logic [N-1:0]  sync1_q, sync2_q;
   logic [N-1:0]  cand_q, cand_d;
   logic [N-1:0]  st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  code_q, code_d;
   logic          valid_q, valid_d;
   logic          multi_q, multi_d;
   logic          changed_q, changed_d;

   logic [W-1:0]  hi_code;
   logic [PW-1:0] pop;

   // Debounce: any movement at sync2 restarts the stability count
   always_comb begin
      cand_d = cand_q;
      st_d   = st_q;
      cnt_d  = cnt_q;
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cand_q != st_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            st_d  = cand_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Encoder: later iterations override, so the highest set bit wins
   always_comb begin
      hi_code = '0;
      pop     = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (st_q[i]) begin
            hi_code = W'(i + 1);
            pop     = pop + PW'(1);
         end
      end
      multi_d   = (pop > PW'(1));
      code_d    = ((STRICT != 0) && (pop != PW'(1))) ? '0 : hi_code;
      valid_d   = (code_d != '0);
      changed_d = (code_d != code_q);
   end

   // State registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cand_q    <= '0;
         st_q      <= '0;
         cnt_q     <= '0;
         code_q    <= '0;
         valid_q   <= 1'b0;
         multi_q   <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         sync1_q   <= switch_i;
         sync2_q   <= sync1_q;
         cand_q    <= cand_d;
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         multi_q   <= multi_d;
         changed_q <= changed_d;
      end
   end

   assign code_o    = code_q;
   assign valid_o   = valid_q;
   assign multi_o   = multi_q;
   assign changed_o = changed_q;

endmodule

// File: tb/tb_switch_priority_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_priority_debouncer
//   Drives a priority-mode and a strict-mode instance from the same switch bank
//   and checks codes, flags and change pulses against hand-computed values.
// -----------------------------------------------------------------------------
module tb_switch_priority_debouncer;

   localparam int unsigned N = 9;
   localparam int unsigned W = 4;
   localparam int unsigned D = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] sw;
   logic [W-1:0] code_p, code_s;
   logic         valid_p, valid_s, multi_p, multi_s, changed_p, changed_s;

   int n_cmp = 0;
   int n_bad = 0;
   int cur_p = 0;
   int cur_s = 0;

   always #5 clk = ~clk;

   switch_priority_debouncer #(.N(N), .W(W), .DEBOUNCE_CYCLES(D), .STRICT(0)) dut_p (
      .clk_i(clk), .rst_i(rst), .switch_i(sw),
      .code_o(code_p), .valid_o(valid_p), .multi_o(multi_p), .changed_o(changed_p)
   );

   switch_priority_debouncer #(.N(N), .W(W), .DEBOUNCE_CYCLES(D), .STRICT(1)) dut_s (
      .clk_i(clk), .rst_i(rst), .switch_i(sw),
      .code_o(code_s), .valid_o(valid_s), .multi_o(multi_s), .changed_o(changed_s)
   );

   typedef struct {
      logic [N-1:0] sw;
      int code_p; int multi_p;
      int code_s; int multi_s;
      int pulses_p; int pulses_s;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Input was driven at a negedge; the next posedge is E0 and the new
   // outputs must appear exactly at E0+D+3, with nothing moving before.
   task automatic latency(input string nm, input int np, input int mp,
                          input int ns, input int ms);
      for (int k = 1; k <= int'(D) + 3; k++) begin
         step();
         chk({nm, "_hold_code_p"}, int'(code_p), cur_p);
         chk({nm, "_hold_chg_p"},  int'(changed_p), 0);
         chk({nm, "_hold_code_s"}, int'(code_s), cur_s);
         chk({nm, "_hold_chg_s"},  int'(changed_s), 0);
      end
      step();
      chk({nm, "_code_p"},  int'(code_p), np);
      chk({nm, "_valid_p"}, int'(valid_p), int'(np != 0));
      chk({nm, "_multi_p"}, int'(multi_p), mp);
      chk({nm, "_chg_p"},   int'(changed_p), int'(np != cur_p));
      chk({nm, "_code_s"},  int'(code_s), ns);
      chk({nm, "_valid_s"}, int'(valid_s), int'(ns != 0));
      chk({nm, "_multi_s"}, int'(multi_s), ms);
      chk({nm, "_chg_s"},   int'(changed_s), int'(ns != cur_s));
      step();
      chk({nm, "_chg_p_drop"}, int'(changed_p), 0);
      chk({nm, "_chg_s_drop"}, int'(changed_s), 0);
      cur_p = np;
      cur_s = ns;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_code_p"},  int'(code_p), 0);
      chk({nm, "_valid_p"}, int'(valid_p), 0);
      chk({nm, "_multi_p"}, int'(multi_p), 0);
      chk({nm, "_chg_p"},   int'(changed_p), 0);
      chk({nm, "_code_s"},  int'(code_s), 0);
      chk({nm, "_valid_s"}, int'(valid_s), 0);
      chk({nm, "_multi_s"}, int'(multi_s), 0);
      chk({nm, "_chg_s"},   int'(changed_s), 0);
   endtask

   initial begin
      int np, ns;

      // Starting from code 5 (bit 4) in both instances
      tbl[0] = '{9'b100000010, 9, 1, 0, 1, 1, 1};
      tbl[1] = '{9'b100000011, 9, 1, 0, 1, 0, 0};
      tbl[2] = '{9'b000000001, 1, 0, 1, 0, 1, 1};
      tbl[3] = '{9'b000000011, 2, 1, 0, 1, 1, 1};
      tbl[4] = '{9'b000000010, 2, 0, 2, 0, 0, 1};
      tbl[5] = '{9'b100000000, 9, 0, 9, 0, 1, 1};
      tbl[6] = '{9'b000000000, 0, 0, 0, 0, 1, 1};
      tbl[7] = '{9'b110000000, 9, 1, 0, 1, 1, 0};
      tbl[8] = '{9'b111111111, 9, 1, 0, 1, 0, 0};
      tbl[9] = '{9'b010000000, 8, 0, 8, 0, 1, 1};

      rst = 1'b1;
      sw  = 9'h1FF;
      // Reset held three cycles with every switch on
      for (int k = 0; k < 3; k++) begin
         step();
         chk_all_zero("reset");
      end
      rst = 1'b0;
      latency("post_reset", 9, 1, 0, 1);

      sw = 9'b000000000;
      latency("release_all", 0, 0, 0, 0);

      sw = 9'b000000100;
      latency("clean_press", 3, 0, 3, 0);

      // Direct 3 -> 7: the hold checks guarantee no intermediate 0
      sw = 9'b001000000;
      latency("direct", 7, 0, 7, 0);

      sw = 9'b000000000;
      latency("to_zero", 0, 0, 0, 0);

      // Bit 4 bounces with 5-cycle half periods, then settles high
      for (int t = 0; t < 40; t++) begin
         if (t % 5 == 0) sw[4] = ~sw[4];
         step();
         chk("bounce_code_p", int'(code_p), 0);
         chk("bounce_chg_p",  int'(changed_p), 0);
         chk("bounce_chg_s",  int'(changed_s), 0);
      end
      sw[4] = 1'b1;
      latency("bounce_settle", 5, 0, 5, 0);

      // Table-driven vectors: apply, let settle, count pulses
      for (int v = 0; v < 10; v++) begin
         sw = tbl[v].sw;
         np = 0;
         ns = 0;
         for (int k = 0; k < 25; k++) begin
            step();
            np += int'(changed_p);
            ns += int'(changed_s);
         end
         chk($sformatf("vec%0d_code_p", v),   int'(code_p),  tbl[v].code_p);
         chk($sformatf("vec%0d_valid_p", v),  int'(valid_p), int'(tbl[v].code_p != 0));
         chk($sformatf("vec%0d_multi_p", v),  int'(multi_p), tbl[v].multi_p);
         chk($sformatf("vec%0d_pulses_p", v), np,            tbl[v].pulses_p);
         chk($sformatf("vec%0d_code_s", v),   int'(code_s),  tbl[v].code_s);
         chk($sformatf("vec%0d_valid_s", v),  int'(valid_s), int'(tbl[v].code_s != 0));
         chk($sformatf("vec%0d_multi_s", v),  int'(multi_s), tbl[v].multi_s);
         chk($sformatf("vec%0d_pulses_s", v), ns,            tbl[v].pulses_s);
         cur_p = tbl[v].code_p;
         cur_s = tbl[v].code_s;
      end

      // Reset partway through debouncing a new vector discards progress
      sw = 9'b000000100;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("middeb_code_p", int'(code_p), cur_p);
      end
      rst = 1'b1;
      step();
      chk_all_zero("middeb_reset");
      cur_p = 0;
      cur_s = 0;
      rst = 1'b0;
      latency("after_reset", 3, 0, 3, 0);

      // Glitch one cycle shorter than the debounce window never lands
      sw[7] = 1'b1;
      for (int k = 0; k < int'(D) - 1; k++) begin
         step();
         chk("glitch_code_p", int'(code_p), 3);
         chk("glitch_chg_p",  int'(changed_p), 0);
      end
      sw[7] = 1'b0;
      for (int k = 0; k < 30; k++) begin
         step();
         chk("glitch_code_p", int'(code_p), 3);
         chk("glitch_valid_p", int'(valid_p), 1);
         chk("glitch_chg_p",  int'(changed_p), 0);
         chk("glitch_code_s", int'(code_s), 3);
         chk("glitch_chg_s",  int'(changed_s), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/switch_priority_debouncer.md
# switch_priority_debouncer

Parametrised successor of the switch encoder feeding the Sudoku value-entry path. Samples an N-bit bank of asynchronous slide switches, synchronises and debounces the whole vector, then priority- or strictly-encodes the stable vector into a 1-based digit code. Adds a multi-switch flag and a one-cycle change pulse, so downstream cell-write logic acts once per deliberate selection rather than on every sampled clock.

## Interface
- N, default 9: number of switch inputs; bit i encodes to value i+1.
- W, default 4: code width; must satisfy 2^W > N (elaboration-time check, fatal on violation).
- DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a new vector is accepted; must be ≥ 1.
- STRICT, default 0: 0 = priority mode (highest set bit wins); 1 = one-hot mode (multiple set bits produce code 0).

- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- switch  in  N  raw asynchronous switch levels.
- code  out  W  encoded digit: 0 = none/invalid, else index of selected switch + 1.
- valid  out  1  high whenever code ≠ 0.
- multi  out  1  high when more than one bit of the stable vector is set (both modes).
- changed  out  1  one-cycle pulse when code takes a value different from its previous value.

## Operation
- Stage 1–2: two-flop synchroniser, sync1 ← switch, sync2 ← sync1.
- Debounce state: cand (N bits), st (N bits, accepted vector), cnt (ceil(log2(DEBOUNCE_CYCLES+1)) bits).
  - sync2 ≠ cand: cand ← sync2, cnt ← 0.
  - sync2 = cand and cand ≠ st: if cnt = DEBOUNCE_CYCLES−1 then st ← cand, cnt ← 0; else cnt ← cnt+1.
  - sync2 = cand = st: cnt ← 0.
- Encode stage (registered from st):
  - STRICT=0: code ← highest set index + 1; 0 if st = 0.
  - STRICT=1: code ← index+1 only if exactly one bit set; else 0.
  - multi ← popcount(st) > 1; valid ← (next code ≠ 0), registered with code.
  - changed ← (next code ≠ current code).
- Any bounce (sync2 changing) restarts the count; pulses shorter than DEBOUNCE_CYCLES cycles at sync2 never reach st.
- Change between two nonzero codes (e.g. 3→7 in one stable transition) produces a single changed pulse, no intermediate 0.
- Changes to multi alone, with code unchanged (priority mode, lower bit added), do not pulse changed.

## Timing
- Reset: sync1, sync2, cand, st, cnt, code, valid, multi, changed all 0 on the edge where rst=1; held while rst=1.
- Reset mid-debounce discards progress; after rst falls, a held vector needs the full latency again.
- Latency: input change set up before edge E0 → code/valid/multi/changed update at edge E0+DEBOUNCE_CYCLES+3 (20 edges total for default 16, counting E0).
- changed high for exactly one cycle, coincident with the new code.
- No output depends combinationally on switch.

## Test plan
- Reset: rst=1 for 3 cycles with switch=9'h1FF → code=0, valid=0, multi=0, changed=0 throughout; after release code=9, multi=1 exactly DEBOUNCE_CYCLES+3 edges after the first post-reset edge, one changed pulse.
- Clean press, N=9, D=16, STRICT=0: switch 0→9'b000000100 at E0 → code=3, valid=1, changed pulse at E0+19, nothing before.
- Bounce: toggle bit 4 every 5 cycles for 40 cycles then hold 1 → no output change during bouncing; code=5 19 edges after last toggle, single changed pulse.
- Priority vs strict: stable 9'b100000010 → STRICT=0 code=9, multi=1, valid=1; STRICT=1 code=0, valid=0, multi=1, no changed pulse if code was already 0.
- Direct transition: stable 9'b000000100 → 9'b001000000 in one step → code goes 3→7 with one changed pulse, code never 0 between.
- Short glitch: single-bit pulse of DEBOUNCE_CYCLES−1 cycles → code, valid, changed never move.
